// File: rtl/wr_addr_gen.sv
// Per-bank write address generator for the decoder write-back phase: base row counter plus static per-slot offsets.
// Optional sticky overrun flag wr_err is built when WR_ADDR_GEN_ERR_EN is defined.
module wr_addr_gen #(
    parameter int unsigned A_WID = 8,
    parameter int unsigned NBANK = 36
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [3:0]                 fsm,
    input  logic [1:0]                 cycle,
    input  logic                       in_vld,
    input  logic [A_WID-1:0]           row_cnt,
    input  logic [NBANK*3*A_WID-1:0]   wr_offset,
    output logic [NBANK*A_WID-1:0]     wr_addr,
    output logic [NBANK-1:0]           wr_we,
    output logic [A_WID-1:0]           wr_base,
    output logic                       wr_busy,
`ifdef WR_ADDR_GEN_ERR_EN
    output logic                       wr_err,
`endif
    output logic                       wr_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [A_WID-1:0]         base_q, base_d;
    logic [NBANK*A_WID-1:0]   addr_q, addr_d;
    logic [NBANK-1:0]         we_q, we_d;
    logic                     done_q, done_d;
    logic                     busy_q, busy_d;
    logic                     wen;
    logic [A_WID-1:0]         row_last;
    int unsigned              slot;
    logic                     unused_fsm;

    assign wen        = fsm[3];
    assign unused_fsm = ^fsm[2:0];
    // row_cnt=0 wraps to all-ones, so a zero count runs the full 2^A_WID rows
    assign row_last   = row_cnt - A_WID'(1);
    assign slot       = 32'(cycle);

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        addr_d  = addr_q;
        we_d    = '0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (wen) begin
                    state_d = RUN;
                    base_d  = '0;
                end
            end
            RUN: begin
                if (!wen) begin
                    state_d = IDLE;
                    base_d  = '0;
                end else if (in_vld) begin
                    if (cycle == 2'd3) begin
                        if (base_q == row_last) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                            base_d  = '0;
                        end else begin
                            base_d = base_q + A_WID'(1);
                        end
                    end else begin
                        we_d = '1;
                        for (int unsigned b = 0; b < NBANK; b++) begin
                            addr_d[b*A_WID +: A_WID] =
                                base_q + wr_offset[(3*b + slot)*A_WID +: A_WID];
                        end
                    end
                end
            end
            DONE: begin
                if (!wen) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            base_q  <= '0;
            addr_q  <= '0;
            we_q    <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign wr_addr = addr_q;
    assign wr_we   = we_q;
    assign wr_base = base_q;
    assign wr_busy = busy_q;
    assign wr_done = done_q;

`ifdef WR_ADDR_GEN_ERR_EN
    logic err_q, err_d;

    // Data arriving outside RUN is an overrun; it wins over the clear on the same edge.
    always_comb begin
        err_d = err_q;
        if (state_q == IDLE && state_d == RUN) begin
            err_d = 1'b0;
        end
        if ((state_q == IDLE || state_q == DONE) && wen && in_vld) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign wr_err = err_q;
`endif

endmodule

// File: tb/tb_wr_addr_gen.sv
// Directed self-checking bench for wr_addr_gen; covers wr_err when WR_ADDR_GEN_ERR_EN is defined.
module tb_wr_addr_gen;

    localparam int unsigned AW = 8;
    localparam int unsigned NB = 36;

    logic                  clk;
    logic                  reset;
    logic [3:0]            fsm;
    logic [1:0]            cycle;
    logic                  in_vld;
    logic [AW-1:0]         row_cnt;
    logic [NB*3*AW-1:0]    wr_offset;
    logic [NB*AW-1:0]      wr_addr;
    logic [NB-1:0]         wr_we;
    logic [AW-1:0]         wr_base;
    logic                  wr_busy;
    logic                  wr_done;
`ifdef WR_ADDR_GEN_ERR_EN
    logic                  wr_err;
`endif

    int total = 0;
    int bad   = 0;

    wr_addr_gen #(.A_WID(AW), .NBANK(NB)) dut (
        .clk       (clk),
        .reset     (reset),
        .fsm       (fsm),
        .cycle     (cycle),
        .in_vld    (in_vld),
        .row_cnt   (row_cnt),
        .wr_offset (wr_offset),
        .wr_addr   (wr_addr),
        .wr_we     (wr_we),
        .wr_base   (wr_base),
        .wr_busy   (wr_busy),
`ifdef WR_ADDR_GEN_ERR_EN
        .wr_err    (wr_err),
`endif
        .wr_done   (wr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [AW-1:0] bank_addr(input int b);
        return wr_addr[b*AW +: AW];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; fsm = 4'h0; cycle = 2'd0; in_vld = 1'b0; row_cnt = 8'd2;
        wr_offset = '0;
        wr_offset[(3*9+0)*AW +: AW] = 8'd65;
        wr_offset[(3*9+1)*AW +: AW] = 8'd129;
        wr_offset[(3*9+2)*AW +: AW] = 8'd0;
        tick(); tick();
        total++; if (wr_addr !== '0) begin bad++; $display("FAIL reset_addr got=%h exp=0", wr_addr); end
        total++; if (wr_we !== '0) begin bad++; $display("FAIL reset_we got=%h exp=0", wr_we); end
        total++; if (wr_base !== 8'd0) begin bad++; $display("FAIL reset_base got=%0d exp=0", wr_base); end
        total++; if (wr_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", wr_busy); end
        total++; if (wr_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", wr_done); end
`ifdef WR_ADDR_GEN_ERR_EN
        total++; if (wr_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", wr_err); end
`endif
        #2 reset = 1'b0;
        tick();
        total++; if (wr_busy !== 1'b0) begin bad++; $display("FAIL idle_hold_busy got=%b exp=0", wr_busy); end
    endtask

    task automatic test_basic();
        logic [AW-1:0] exp_a [8];
        exp_a = '{8'd65, 8'd129, 8'd0, 8'd0, 8'd66, 8'd130, 8'd1, 8'd0};
        row_cnt = 8'd2;
        fsm = 4'h8; in_vld = 1'b0;
        tick();
        total++; if (wr_busy !== 1'b1) begin bad++; $display("FAIL basic_enter_busy got=%b exp=1", wr_busy); end
        total++; if (wr_base !== 8'd0) begin bad++; $display("FAIL basic_enter_base got=%0d exp=0", wr_base); end
        in_vld = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle = 2'(i % 4);
            tick();
            if (i % 4 != 3) begin
                total++; if (bank_addr(9) !== exp_a[i]) begin bad++; $display("FAIL basic_addr%0d got=%0d exp=%0d", i, bank_addr(9), exp_a[i]); end
                total++; if (wr_we !== '1) begin bad++; $display("FAIL basic_we%0d got=%h exp=all1", i, wr_we); end
            end else begin
                total++; if (wr_we !== '0) begin bad++; $display("FAIL basic_turn_we%0d got=%h exp=0", i, wr_we); end
            end
            if (i == 3) begin
                total++; if (wr_base !== 8'd1) begin bad++; $display("FAIL basic_base1 got=%0d exp=1", wr_base); end
                total++; if (wr_done !== 1'b0) begin bad++; $display("FAIL basic_early_done got=%b exp=0", wr_done); end
            end
        end
        total++; if (wr_done !== 1'b1) begin bad++; $display("FAIL basic_done got=%b exp=1", wr_done); end
        total++; if (wr_base !== 8'd0) begin bad++; $display("FAIL basic_done_base got=%0d exp=0", wr_base); end
        total++; if (wr_busy !== 1'b0) begin bad++; $display("FAIL basic_done_busy got=%b exp=0", wr_busy); end
        in_vld = 1'b0;
        tick();
        total++; if (wr_done !== 1'b0) begin bad++; $display("FAIL basic_done_width got=%b exp=0", wr_done); end
        in_vld = 1'b1; cycle = 2'd0;
        tick();
        total++; if (wr_we !== '0) begin bad++; $display("FAIL done_vld_we got=%h exp=0", wr_we); end
        total++; if (bank_addr(9) !== 8'd1) begin bad++; $display("FAIL done_vld_addr got=%0d exp=1", bank_addr(9)); end
        total++; if (wr_busy !== 1'b0) begin bad++; $display("FAIL done_stays got=%b exp=0", wr_busy); end
`ifdef WR_ADDR_GEN_ERR_EN
        total++; if (wr_err !== 1'b1) begin bad++; $display("FAIL err_set got=%b exp=1", wr_err); end
`endif
        in_vld = 1'b0; fsm = 4'h0;
        tick();
`ifdef WR_ADDR_GEN_ERR_EN
        total++; if (wr_err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", wr_err); end
`endif
        fsm = 4'h8;
        tick();
        total++; if (wr_busy !== 1'b1) begin bad++; $display("FAIL reenter_busy got=%b exp=1", wr_busy); end
`ifdef WR_ADDR_GEN_ERR_EN
        total++; if (wr_err !== 1'b0) begin bad++; $display("FAIL err_clear got=%b exp=0", wr_err); end
`endif
        fsm = 4'h0;
        tick();
    endtask

    task automatic test_gap_and_abort();
        row_cnt = 8'd8;
        fsm = 4'h8; in_vld = 1'b0;
        tick();
        in_vld = 1'b1; cycle = 2'd0; tick();
        total++; if (bank_addr(9) !== 8'd65) begin bad++; $display("FAIL gap_c0 got=%0d exp=65", bank_addr(9)); end
        in_vld = 1'b0; cycle = 2'd1; tick();
        total++; if (wr_we !== '0) begin bad++; $display("FAIL gap_we got=%h exp=0", wr_we); end
        total++; if (bank_addr(9) !== 8'd65) begin bad++; $display("FAIL gap_hold got=%0d exp=65", bank_addr(9)); end
        in_vld = 1'b1; cycle = 2'd2; tick();
        total++; if (bank_addr(9) !== 8'd0) begin bad++; $display("FAIL gap_c2 got=%0d exp=0", bank_addr(9)); end
        in_vld = 1'b0; cycle = 2'd3; tick();
        total++; if (wr_base !== 8'd0) begin bad++; $display("FAIL gap_noinc got=%0d exp=0", wr_base); end
        in_vld = 1'b1; tick();
        total++; if (wr_base !== 8'd1) begin bad++; $display("FAIL gap_inc got=%0d exp=1", wr_base); end
        repeat (4) tick();
        total++; if (wr_base !== 8'd5) begin bad++; $display("FAIL abort_pre got=%0d exp=5", wr_base); end
        fsm = 4'h0; cycle = 2'd0; tick();
        total++; if (wr_busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", wr_busy); end
        total++; if (wr_base !== 8'd0) begin bad++; $display("FAIL abort_base got=%0d exp=0", wr_base); end
        total++; if (wr_we !== '0) begin bad++; $display("FAIL abort_we got=%h exp=0", wr_we); end
        total++; if (wr_done !== 1'b0) begin bad++; $display("FAIL abort_done got=%b exp=0", wr_done); end
        in_vld = 1'b0; fsm = 4'h8; tick();
        total++; if (wr_busy !== 1'b1) begin bad++; $display("FAIL restart_busy got=%b exp=1", wr_busy); end
        in_vld = 1'b1; cycle = 2'd0; tick();
        total++; if (bank_addr(9) !== 8'd65) begin bad++; $display("FAIL restart_c0 got=%0d exp=65", bank_addr(9)); end
        cycle = 2'd1; tick();
        total++; if (bank_addr(9) !== 8'd129) begin bad++; $display("FAIL restart_c1 got=%0d exp=129", bank_addr(9)); end
        in_vld = 1'b0; fsm = 4'h0; tick();
    endtask

    task automatic test_wrap();
        wr_offset[(3*9+0)*AW +: AW] = 8'd255;
        wr_offset[(3*8+0)*AW +: AW] = 8'd1;
        row_cnt = 8'd0;
        fsm = 4'h8; in_vld = 1'b0; tick();
        in_vld = 1'b1; cycle = 2'd3;
        repeat (250) tick();
        total++; if (wr_base !== 8'd250) begin bad++; $display("FAIL wrap_base got=%0d exp=250", wr_base); end
        total++; if (wr_done !== 1'b0) begin bad++; $display("FAIL wrap_nodone got=%b exp=0", wr_done); end
        cycle = 2'd0; tick();
        total++; if (bank_addr(9) !== 8'd249) begin bad++; $display("FAIL wrap_b9 got=%0d exp=249", bank_addr(9)); end
        total++; if (bank_addr(8) !== 8'd251) begin bad++; $display("FAIL wrap_b8 got=%0d exp=251", bank_addr(8)); end
        total++; if (bank_addr(10) !== 8'd250) begin bad++; $display("FAIL wrap_b10 got=%0d exp=250", bank_addr(10)); end
        cycle = 2'd3;
        repeat (5) tick();
        total++; if (wr_base !== 8'd255) begin bad++; $display("FAIL row0_base got=%0d exp=255", wr_base); end
        total++; if (wr_done !== 1'b0) begin bad++; $display("FAIL row0_early got=%b exp=0", wr_done); end
        tick();
        total++; if (wr_done !== 1'b1) begin bad++; $display("FAIL row0_done got=%b exp=1", wr_done); end
        total++; if (wr_base !== 8'd0) begin bad++; $display("FAIL row0_clr got=%0d exp=0", wr_base); end
        in_vld = 1'b0; fsm = 4'h0; tick();
        wr_offset[(3*9+0)*AW +: AW] = 8'd65;
    endtask

    task automatic test_async_reset();
        row_cnt = 8'd4;
        fsm = 4'h8; in_vld = 1'b0; tick();
        in_vld = 1'b1; cycle = 2'd0; tick();
        total++; if (bank_addr(9) !== 8'd65) begin bad++; $display("FAIL ar_pre got=%0d exp=65", bank_addr(9)); end
        #2 reset = 1'b1;
        #1;
        total++; if (wr_addr !== '0) begin bad++; $display("FAIL ar_addr got=%h exp=0", wr_addr); end
        total++; if (wr_we !== '0) begin bad++; $display("FAIL ar_we got=%h exp=0", wr_we); end
        total++; if (wr_busy !== 1'b0) begin bad++; $display("FAIL ar_busy got=%b exp=0", wr_busy); end
        total++; if (wr_base !== 8'd0) begin bad++; $display("FAIL ar_base got=%0d exp=0", wr_base); end
        total++; if (wr_done !== 1'b0) begin bad++; $display("FAIL ar_done got=%b exp=0", wr_done); end
        @(posedge clk);
        #2 reset = 1'b0;
        tick();
        total++; if (wr_we !== '0) begin bad++; $display("FAIL ar_first_vld got=%h exp=0", wr_we); end
        total++; if (wr_busy !== 1'b1) begin bad++; $display("FAIL ar_run got=%b exp=1", wr_busy); end
        tick();
        total++; if (bank_addr(9) !== 8'd65) begin bad++; $display("FAIL ar_resume got=%0d exp=65", bank_addr(9)); end
        in_vld = 1'b0; fsm = 4'h0; tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gap_and_abort();
        test_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
